seq_mul_add6: RTL and testbench

Sequential shift-add multiply-accumulate unit computing P = Q*B + R. It is the inverse of the datapath's 6-bit array divider: it rebuilds a dividend from quotient, divisor and remainder. It is used in the calculator as the multiply operation (R=0). It is also used as the hardware self-check for division results. One multiplier bit is processed per clock under a start/busy/done handshake.

---
 rtl/seq_mul_add6.sv | 120 ++++++++++++
 tb/tb_seq_mul_add6.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_add6.sv
// Sequential shift-add multiply-accumulate: P = Q*B + R, one multiplier bit per clock.
// Rebuilds a dividend from quotient/divisor/remainder and flags range and remainder validity.
module seq_mul_add6 #(
   parameter int W = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [W-1:0]   Q,
   input  logic [W-1:0]   B,
   input  logic [W-1:0]   R,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] P,
   output logic           ovf,
   output logic           rem_ok
);

   // state | meaning
   // IDLE  | waiting for start, result held
   // RUN   | one shift-add step per clock, cnt = bit being processed
   // DONE  | result just registered, done pulse; may accept a new start

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    q_lat_q, q_lat_d;
   logic [W-1:0]    b_lat_q, b_lat_d;
   logic [W-1:0]    r_lat_q, r_lat_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2*W-1:0]  p_q, p_d;
   logic            ovf_q, ovf_d;
   logic            rem_ok_q, rem_ok_d;

   logic [2*W-1:0]  addend;
   logic [2*W-1:0]  acc_step;

   always_comb begin
      state_d  = state_q;
      q_lat_d  = q_lat_q;
      b_lat_d  = b_lat_q;
      r_lat_d  = r_lat_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      ovf_d    = ovf_q;
      rem_ok_d = rem_ok_q;

      addend   = {{W{1'b0}}, b_lat_q} << cnt_q;
      acc_step = acc_q + (q_lat_q[cnt_q] ? addend : '0);

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               q_lat_d = Q;
               b_lat_d = B;
               r_lat_d = R;
               acc_d   = {{W{1'b0}}, R};
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d = acc_step;
            cnt_d = cnt_q + 1'b1;
            // Final step: the result is taken straight from this step's sum.
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               p_d      = acc_step;
               ovf_d    = |acc_step[2*W-1:W];
               rem_ok_d = (r_lat_q < b_lat_q);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         q_lat_q  <= '0;
         b_lat_q  <= '0;
         r_lat_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         p_q      <= '0;
         ovf_q    <= 1'b0;
         rem_ok_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_lat_q  <= q_lat_d;
         b_lat_q  <= b_lat_d;
         r_lat_q  <= r_lat_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         ovf_q    <= ovf_d;
         rem_ok_q <= rem_ok_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign P      = p_q;
   assign ovf    = ovf_q;
   assign rem_ok = rem_ok_q;

endmodule

// File: tb/tb_seq_mul_add6.sv
// Scoreboard bench for seq_mul_add6: expected results queued at accepted start,
// compared (value, flags, latency) on every done pulse.
module tb_seq_mul_add6;

   localparam int W = 6;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   Q, B, R;
   logic           busy, done;
   logic [2*W-1:0] P;
   logic           ovf, rem_ok;

   typedef struct {
      logic [2*W-1:0] p;
      logic           ovf;
      logic           rem_ok;
      int             acc_cyc;
   } exp_t;

   exp_t           sb[$];
   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   int             n_accept = 0;
   int             n_done = 0;
   logic [2*W-1:0] last_p = '0;

   seq_mul_add6 #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .Q      (Q),
      .B      (B),
      .R      (R),
      .busy   (busy),
      .done   (done),
      .P      (P),
      .ovf    (ovf),
      .rem_ok (rem_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] q, input logic [W-1:0] b,
                                  input logic [W-1:0] r);
      exp_t e;
      e.p       = (2*W)'(q) * (2*W)'(b) + (2*W)'(r);
      e.ovf     = (e.p[2*W-1:W] != '0);
      e.rem_ok  = (r < b);
      e.acc_cyc = 0;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("P", 32'(P), 32'(e.p));
            chk("ovf", 32'(ovf), 32'(e.ovf));
            chk("rem_ok", 32'(rem_ok), 32'(e.rem_ok));
            chk("latency", 32'(cyc - e.acc_cyc), 32'(W));
            chk("busy_at_done", 32'(busy), 0);
            last_p = e.p;
         end
      end
   end

   // Called at a negedge with the unit free; accepts at the next posedge.
   task automatic issue(input logic [W-1:0] q, input logic [W-1:0] b, input logic [W-1:0] r);
      exp_t e;
      Q = q; B = b; R = r; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e = model(q, b, r);
      e.acc_cyc = cyc;
      sb.push_back(e);
      n_accept++;
      chk("busy_after_start", 32'(busy), 1);
      chk("done_after_start", 32'(done), 0);
   endtask

   // Returns at the negedge where done is high; P must hold meanwhile.
   task automatic wait_done();
      int n = 0;
      while (!done && n < 20) begin
         if (P !== last_p) chk("P_hold_run", 32'(P), 32'(last_p));
         @(negedge clk);
         n++;
      end
      if (!done) chk("timeout_done", 0, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; Q = '0; B = '0; R = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_P", 32'(P), 0);
      chk("rst_flags", 32'({ovf, rem_ok}), 0);
      rst = 1'b0;
      @(negedge clk);

      // Basic multiply and divider-inverse cases.
      issue(7, 9, 0);    wait_done(); @(negedge clk);
      issue(5, 12, 3);   wait_done(); @(negedge clk);
      issue(63, 63, 62); wait_done(); @(negedge clk);
      issue(63, 0, 17);  wait_done(); @(negedge clk);
      issue(0, 40, 40);  wait_done(); @(negedge clk);
      issue(63, 63, 63); wait_done(); @(negedge clk);
      chk("P_4032", 32'(P), 4032);

      // Reset in the middle of an operation discards it.
      issue(63, 63, 63);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      chk("midrst_P", 32'(P), 0);
      void'(sb.pop_back());
      n_accept--;
      last_p = '0;
      repeat (8) begin
         @(negedge clk);
         if (done) chk("midrst_no_done", 1, 0);
      end
      issue(2, 3, 0); wait_done(); @(negedge clk);
      chk("after_rst_P", 32'(P), 6);

      // start pulses while running are ignored.
      issue(7, 9, 0);
      repeat (3) begin
         Q = 6'(~7); B = 6'd1; R = 6'd5; start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      wait_done(); @(negedge clk);
      chk("run_start_ignored", 32'(P), 63);

      // Result held in IDLE while inputs toggle.
      for (int i = 0; i < 12; i++) begin
         Q = 6'($urandom); B = 6'($urandom); R = 6'($urandom);
         @(negedge clk);
         if (i % 4 == 0) chk("P_hold_idle", 32'(P), 63);
         else if (P !== 12'd63) chk("P_hold_idle", 32'(P), 63);
      end

      // start held high: new op accepted in every DONE cycle.
      for (int i = 0; i < 5; i++) begin
         logic [W-1:0] q, b, r;
         exp_t e;
         q = 6'($urandom); b = 6'($urandom); r = 6'($urandom);
         Q = q; B = b; R = r; start = 1'b1;
         @(negedge clk);
         e = model(q, b, r);
         e.acc_cyc = cyc;
         sb.push_back(e);
         n_accept++;
         repeat (W) @(negedge clk);
         chk("b2b_done", 32'(done), 1);
      end
      start = 1'b0;
      @(negedge clk);
      chk("b2b_idle", 32'({busy, done}), 0);

      // Random operands with random gaps (gap 0 accepts straight from DONE).
      for (int i = 0; i < 500; i++) begin
         int gap;
         issue(6'($urandom), 6'($urandom), 6'($urandom));
         wait_done();
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
      end
      repeat (3) @(negedge clk);

      chk("sb_empty", 32'(sb.size()), 0);
      chk("done_count", 32'(n_done), 32'(n_accept));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
